// File: rtl/tdm_demux8.sv
// TDM receive demultiplexer: rebuilds 8 parallel channels from a slot-ordered word stream.
// Optional framing check enabled by defining TDM_DEMUX_SYNC_CHECK_EN.
module tdm_demux8 #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] e,
    output logic [DATA_W-1:0] f,
    output logic [DATA_W-1:0] g,
    output logic [DATA_W-1:0] h,
    output logic              frame_valid,
    output logic [2:0]        slot,
    output logic              sync_err
);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]        state_reg, state_next;
    logic [2:0]        slot_reg, slot_next;
    logic              frame_valid_reg;
    logic              sync_err_reg, sync_err_next;
    logic              shadow_we;
    logic              frame_done;
    logic [2:0]        shadow_idx;
    logic [DATA_W-1:0] shadow_reg [0:6];
    logic [DATA_W-1:0] out_reg    [0:7];

    // A sync-qualified word always lands in slot 0, whatever slot was expected.
    assign shadow_idx = frame_sync ? 3'd0 : slot_reg;

    always_comb begin
        state_next    = state_reg;
        slot_next     = slot_reg;
        shadow_we     = 1'b0;
        frame_done    = 1'b0;
        sync_err_next = 1'b0;
        if (din_valid) begin
            if (state_reg == HUNT) begin
                if (frame_sync) begin
                    shadow_we  = 1'b1;
                    slot_next  = 3'd1;
                    state_next = LOCK;
                end
            end else if (frame_sync) begin
                shadow_we = 1'b1;
                slot_next = 3'd1;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                sync_err_next = (slot_reg != 3'd0);
`endif
            end else if (slot_reg == 3'd0) begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                sync_err_next = 1'b1;
                state_next    = HUNT;
`else
                shadow_we = 1'b1;
                slot_next = 3'd1;
`endif
            end else if (slot_reg == 3'd7) begin
                frame_done = 1'b1;
                slot_next  = 3'd0;
            end else begin
                shadow_we = 1'b1;
                slot_next = slot_reg + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= HUNT;
            slot_reg        <= 3'd0;
            frame_valid_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            slot_reg        <= slot_next;
            frame_valid_reg <= frame_done;
            sync_err_reg    <= sync_err_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_shadow
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg[gi] <= '0;
                end else if (shadow_we && (shadow_idx == 3'(gi))) begin
                    shadow_reg[gi] <= din;
                end
            end
        end

        // The last word bypasses the shadow bank so the frame lands the cycle after its accept.
        for (gi = 0; gi < 8; gi++) begin : g_out
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_reg[gi] <= '0;
                end else if (frame_done) begin
                    if (gi < 7) begin
                        out_reg[gi] <= shadow_reg[gi];
                    end else begin
                        out_reg[gi] <= din;
                    end
                end
            end
        end
    endgenerate

    assign a           = out_reg[0];
    assign b           = out_reg[1];
    assign c           = out_reg[2];
    assign d           = out_reg[3];
    assign e           = out_reg[4];
    assign f           = out_reg[5];
    assign g           = out_reg[6];
    assign h           = out_reg[7];
    assign frame_valid = frame_valid_reg;
    assign slot        = slot_reg;
    assign sync_err    = sync_err_reg;

endmodule
